cn_c2v_gen: RTL and testbench

Check-node C2V generator for the column-layered min-sum LDPC decoder. It consumes the compressed check-node state produced during V2C collection: {min2, min1}, the min1 column index, the total sign, and the per-column V2C signs streamed in collection order. It then replays one offset-min-sum C2V message per column toward the variable-node update. Per-column sign storage is ping-pong, so collection of row k+1 overlaps emission of row k.

---
 rtl/cn_c2v_gen.sv | 175 +++++++++++++++++
 tb/tb_cn_c2v_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cn_c2v_gen.sv
// Check-node C2V generator: replays offset-min-sum C2V messages per column from the
// compressed row state, with ping-pong sign banks so collection overlaps emission.
module cn_c2v_gen #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 7,
  parameter int ROW_DEG     = 32,
  parameter int OFFSET      = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_sign_vld,
  input  logic                         i_sign,
  input  logic                         i_load,
  input  logic [(MSG_WIDTH-1)*2-1:0]   i_v2c_abs,
  input  logic [COL_CNT_WID-1:0]       i_v2c_idx,
  input  logic                         i_sign_tot,
  output logic                         o_load_rdy,
  output logic                         o_load_err,
  output logic                         o_vld,
  input  logic                         i_rdy,
  output logic [MSG_WIDTH-1:0]         o_c2v,
  output logic [COL_CNT_WID-1:0]       o_col_cnt,
  output logic                         o_last
);

  localparam int MAG_W = MSG_WIDTH - 1;
  localparam int AW    = (ROW_DEG > 1) ? $clog2(ROW_DEG) : 1;
  localparam logic [COL_CNT_WID-1:0] DEG_C = COL_CNT_WID'(ROW_DEG);
  localparam logic [COL_CNT_WID-1:0] ONE_C = COL_CNT_WID'(1);
  localparam logic [MAG_W-1:0]       OFS_C = MAG_W'(OFFSET);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    wr_bank_r;
  logic                    rd_bank_r;
  logic [COL_CNT_WID-1:0]  wr_ptr_r;
  logic [COL_CNT_WID-1:0]  rd_ptr_r;
  logic [COL_CNT_WID-1:0]  len_r;
  logic [COL_CNT_WID-1:0]  len_nxt_s;
  logic [COL_CNT_WID-1:0]  idx_r;
  logic [MAG_W-1:0]        min1_r;
  logic [MAG_W-1:0]        min2_r;
  logic                    sign_tot_r;
  logic                    load_err_r;
  logic [ROW_DEG-1:0]      bank_r [2];
  logic                    wr_ok_s;
  logic                    hs_s;
  logic                    load_acc_s;
  logic [MAG_W-1:0]        sel_s;
  logic [MAG_W-1:0]        mag_s;
  logic                    sbit_s;

  function automatic logic [MAG_W-1:0] offset_mag(input logic [MAG_W-1:0] sel);
    return (sel > OFS_C) ? (sel - OFS_C) : {MAG_W{1'b0}};
  endfunction

  // Writes past ROW_DEG are dropped; the pointer saturates there.
  assign wr_ok_s    = i_sign_vld & (wr_ptr_r != DEG_C);
  assign hs_s       = o_vld & i_rdy;
  assign o_load_rdy = (state_r == ST_IDLE) | (hs_s & o_last);
  assign load_acc_s = i_load & o_load_rdy;
  assign len_nxt_s  = wr_ptr_r + (wr_ok_s ? ONE_C : {COL_CNT_WID{1'b0}});
  assign o_load_err = load_err_r;

  // Per-column sign storage (contents are don't-care after reset).
  always_ff @(posedge i_clk) begin
    if (wr_ok_s) begin
      bank_r[wr_bank_r][wr_ptr_r[AW-1:0]] <= i_sign;
    end
  end

  // Write-side pointer and bank select.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r  <= {COL_CNT_WID{1'b0}};
      wr_bank_r <= 1'b0;
    end else if (load_acc_s) begin
      wr_ptr_r  <= {COL_CNT_WID{1'b0}};
      wr_bank_r <= ~wr_bank_r;
    end else if (wr_ok_s) begin
      wr_ptr_r  <= wr_ptr_r + ONE_C;
    end else begin
      wr_ptr_r  <= wr_ptr_r;
    end
  end

  // Row context latched on load, plus the emission read pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      min1_r     <= {MAG_W{1'b0}};
      min2_r     <= {MAG_W{1'b0}};
      idx_r      <= {COL_CNT_WID{1'b0}};
      sign_tot_r <= 1'b0;
      len_r      <= {COL_CNT_WID{1'b0}};
      rd_bank_r  <= 1'b0;
      rd_ptr_r   <= {COL_CNT_WID{1'b0}};
    end else if (load_acc_s) begin
      min1_r     <= i_v2c_abs[MAG_W-1:0];
      min2_r     <= i_v2c_abs[2*MAG_W-1:MAG_W];
      idx_r      <= i_v2c_idx;
      sign_tot_r <= i_sign_tot;
      len_r      <= len_nxt_s;
      rd_bank_r  <= wr_bank_r;
      rd_ptr_r   <= {COL_CNT_WID{1'b0}};
    end else if (hs_s & ~o_last) begin
      rd_ptr_r   <= rd_ptr_r + ONE_C;
    end else begin
      rd_ptr_r   <= rd_ptr_r;
    end
  end

  // FSM state register and dropped-load pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      load_err_r <= i_load & ~o_load_rdy;
    end
  end

  // Next-state: a load on the last handshake chains straight into the next row.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_acc_s && (len_nxt_s != {COL_CNT_WID{1'b0}})) begin
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (hs_s & o_last) begin
          state_nxt_s = (load_acc_s && (len_nxt_s != {COL_CNT_WID{1'b0}})) ? ST_EMIT : ST_IDLE;
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs: idx never matches an out-of-range column, so those rows use min1 throughout.
  always_comb begin
    o_vld     = 1'b0;
    o_c2v     = {MSG_WIDTH{1'b0}};
    o_col_cnt = {COL_CNT_WID{1'b0}};
    o_last    = 1'b0;
    sel_s     = (rd_ptr_r == idx_r) ? min2_r : min1_r;
    mag_s     = offset_mag(sel_s);
    sbit_s    = sign_tot_r ^ bank_r[rd_bank_r][rd_ptr_r[AW-1:0]];
    case (state_r)
      ST_EMIT: begin
        o_vld     = 1'b1;
        o_c2v     = {sbit_s & (mag_s != {MAG_W{1'b0}}), mag_s};
        o_col_cnt = rd_ptr_r;
        o_last    = (rd_ptr_r == (len_r - ONE_C));
      end
      default: begin
        o_vld     = 1'b0;
        o_c2v     = {MSG_WIDTH{1'b0}};
        o_col_cnt = {COL_CNT_WID{1'b0}};
        o_last    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cn_c2v_gen.sv
// Scoreboard bench for cn_c2v_gen: stimulus pushes expected C2V beats computed from
// the min-sum rules; a negedge monitor pops and compares on every handshake.
module tb_cn_c2v_gen;
  localparam int MW = 6, CW = 7, RD = 32, OFS = 1;

  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_sign_vld = 1'b0, i_sign = 1'b0, i_load = 1'b0, i_sign_tot = 1'b0, i_rdy = 1'b1;
  logic [(MW-1)*2-1:0] i_v2c_abs = '0;
  logic [CW-1:0] i_v2c_idx = '0;
  logic o_load_rdy, o_load_err, o_vld, o_last;
  logic [MW-1:0] o_c2v;
  logic [CW-1:0] o_col_cnt;

  cn_c2v_gen #(.MSG_WIDTH(MW), .COL_CNT_WID(CW), .ROW_DEG(RD), .OFFSET(OFS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sign_vld(i_sign_vld), .i_sign(i_sign),
    .i_load(i_load), .i_v2c_abs(i_v2c_abs), .i_v2c_idx(i_v2c_idx), .i_sign_tot(i_sign_tot),
    .o_load_rdy(o_load_rdy), .o_load_err(o_load_err), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_c2v(o_c2v), .o_col_cnt(o_col_cnt), .o_last(o_last));

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [MW-1:0] c2v;
    logic [CW-1:0] col;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  bit   col_q[$];
  int   total = 0, bad = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
    i_sign_vld = 1'b0;
    i_load = 1'b0;
    if (rand_rdy) i_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic put_sign(input bit s);
    i_sign_vld = 1'b1;
    i_sign = s;
    if (col_q.size() < RD) col_q.push_back(s);
  endtask

  // Issue a load and push the row's expected messages from the offset-min-sum rule.
  task automatic load_row(input int m1, input int m2, input int idx, input bit tot);
    int   sel, mag;
    bit   sg;
    exp_t e;
    i_load = 1'b1;
    i_v2c_abs = {(MW-1)'(m2), (MW-1)'(m1)};
    i_v2c_idx = CW'(idx);
    i_sign_tot = tot;
    for (int c = 0; c < col_q.size(); c++) begin
      sel = (c == idx) ? m2 : m1;
      mag = (sel > OFS) ? sel - OFS : 0;
      sg = (mag != 0) ? (tot ^ col_q[c]) : 1'b0;
      e.c2v = {sg, (MW-1)'(mag)};
      e.col = CW'(c);
      e.last = (c == col_q.size() - 1);
      exp_q.push_back(e);
    end
    col_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cyc();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    cyc();
  endtask

  // Monitor: compare each handshaked beat and check outputs hold during stalls.
  exp_t            mon_e;
  bit              stall = 1'b0;
  logic [MW-1:0]   st_c2v;
  logic [CW-1:0]   st_col;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_vld", o_vld, 1);
        chk("hold_c2v", o_c2v, st_c2v);
        chk("hold_col", o_col_cnt, st_col);
      end
      if (o_vld && i_rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got col %0d c2v %0d want none", o_col_cnt, o_c2v);
        end else begin
          total--;
          mon_e = exp_q.pop_front();
          chk("c2v", o_c2v, mon_e.c2v);
          chk("col_cnt", o_col_cnt, mon_e.col);
          chk("last", o_last, mon_e.last);
        end
      end
      stall = o_vld && !i_rdy;
      st_c2v = o_c2v;
      st_col = o_col_cnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int L, m1, m2, idx;
    // Reset state
    #3;
    chk("rst_vld", o_vld, 0);
    chk("rst_last", o_last, 0);
    chk("rst_c2v", o_c2v, 0);
    chk("rst_col", o_col_cnt, 0);
    chk("rst_err", o_load_err, 0);
    chk("rst_rdy", o_load_rdy, 1);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Basic emit: signs 1,0,0,1
    cyc(); put_sign(1);
    cyc(); put_sign(0);
    cyc(); put_sign(0);
    cyc(); put_sign(1);
    cyc(); load_row(3, 7, 2, 1'b0);
    cyc();
    chk("first_vld_latency", o_vld, 1);
    chk("first_col", o_col_cnt, 0);
    drain();

    // Offset floor
    cyc(); put_sign(1);
    cyc(); put_sign(1);
    cyc(); put_sign(0);
    cyc(); load_row(1, 0, 0, 1'b0);
    drain();

    // Backpressure during col 1
    for (int i = 0; i < 4; i++) begin cyc(); put_sign(i[0]); end
    cyc(); load_row(12, 20, 3, 1'b1);
    cyc();
    cyc(); i_rdy = 1'b0;
    cyc();
    cyc(); chk("bp_col_frozen", o_col_cnt, 1);
    cyc(); i_rdy = 1'b1;
    drain();

    // Overlap and back-to-back
    for (int i = 0; i < 5; i++) begin cyc(); put_sign(i == 1 || i == 4); end
    cyc(); load_row(9, 20, 4, 1'b1);
    cyc(); put_sign(1);
    cyc(); put_sign(1);
    cyc(); put_sign(0);
    cyc();
    cyc();
    chk("b2b_last", o_last, 1);
    chk("b2b_rdy", o_load_rdy, 1);
    load_row(5, 6, 1, 1'b0);
    cyc();
    chk("b2b_vld", o_vld, 1);
    chk("b2b_col0", o_col_cnt, 0);
    drain();

    // Load while busy is dropped; signs keep flowing into the open row
    for (int i = 0; i < 6; i++) begin cyc(); put_sign(i[1]); end
    cyc(); load_row(4, 8, 5, 1'b0);
    cyc(); put_sign(1);
    cyc(); put_sign(0);
    chk("busy_rdy", o_load_rdy, 0);
    i_load = 1'b1;
    i_v2c_abs = 10'h3ff;
    cyc(); chk("err_pulse", o_load_err, 1);
    cyc(); chk("err_once", o_load_err, 0);
    drain();
    cyc(); put_sign(1); load_row(2, 31, 2, 1'b1);
    drain();

    // Zero-length row
    cyc(); load_row(5, 6, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("len0_no_vld", o_vld, 0);
      chk("len0_rdy", o_load_rdy, 1);
    end

    // Saturation past ROW_DEG, idx = none
    for (int i = 0; i < RD + 8; i++) begin cyc(); put_sign($urandom_range(0, 1)); end
    cyc(); load_row(17, 25, 127, 1'b1);
    drain();

    // Randomized rows, some with the final sign in the load cycle
    rand_rdy = 1'b1;
    for (int r = 0; r < 30; r++) begin
      L = $urandom_range(1, 12);
      m1 = $urandom_range(0, 31);
      m2 = $urandom_range(m1, 31);
      idx = ($urandom_range(0, 4) == 0) ? 127 : $urandom_range(0, L + 1);
      for (int c = 0; c < L - 1; c++) begin cyc(); put_sign($urandom_range(0, 1)); end
      cyc();
      if ($urandom_range(0, 1) == 1) begin
        put_sign($urandom_range(0, 1));
      end else begin
        put_sign($urandom_range(0, 1));
        cyc();
      end
      load_row(m1, m2, idx, 1'($urandom_range(0, 1)));
      drain();
    end
    rand_rdy = 1'b0;
    i_rdy = 1'b1;

    // Async reset mid-emission
    for (int i = 0; i < 8; i++) begin cyc(); put_sign(1); end
    cyc(); load_row(6, 9, 0, 1'b0);
    cyc();
    cyc();
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    chk("arst_vld", o_vld, 0);
    chk("arst_rdy", o_load_rdy, 1);
    exp_q.delete();
    col_q.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    chk("arst_rel_rdy", o_load_rdy, 1);
    cyc(); put_sign(1);
    cyc(); put_sign(0);
    cyc(); load_row(3, 4, 1, 1'b1);
    cyc();
    chk("arst_next_vld", o_vld, 1);
    chk("arst_next_col0", o_col_cnt, 0);
    drain();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
